mips_main_fsm: RTL and testbench
================================

Name: mips_main_fsm

Overview:
- Main control state machine of the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath mux selects and write enables.
- Produces the 2-bit ALU operation class consumed by the ALU decoder, which combines it with funct to form the ALU control.
- Adds a memory-ready handshake so fetch and data accesses can stall on slow memory.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, load word opcode.
- OP_SW, 6'b101011, store word opcode.
- OP_BEQ, 6'b000100, branch-equal opcode.
- OP_ADDI, 6'b001000, add-immediate opcode.
- OP_J, 6'b000010, jump opcode.

Ports:
- i_clk  input  1  rising-edge clock
- i_rst  input  1  synchronous active-high reset
- i_opcode  input  6  instr[31:26] from the instruction register
- i_mem_ready  input  1  memory has completed the current access this cycle
- o_aluop  output  2  00 add, 01 sub, 10 use funct; feeds the ALU decoder
- o_alusrca  output  1  0 = PC, 1 = register A
- o_alusrcb  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- o_pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- o_pcwrite  output  1  unconditional PC write
- o_branch  output  1  PC write if zero flag
- o_iord  output  1  0 = PC address, 1 = ALUOut address
- o_memwrite  output  1  memory write strobe
- o_irwrite  output  1  instruction register load
- o_regdst  output  1  0 = rt, 1 = rd
- o_memtoreg  output  1  0 = ALUOut, 1 = memory data
- o_regwrite  output  1  register file write
- o_illegal  output  1  one-cycle pulse on an unsupported opcode
- o_state  output  4  current state encoding (debug)

Behaviour:
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11
  - Codes 12-15 are unused and go to FETCH on the next clock.
- Reset:
  - i_rst sampled high at a clock edge puts the state in FETCH, regardless of the current state (including mid-access).
  - While i_rst is high, o_pcwrite, o_branch, o_memwrite, o_irwrite, o_regwrite and o_illegal are forced to 0.
  - Other outputs follow the FETCH decode.
- Outputs are a combinational decode of the state. The only exceptions are the i_mem_ready gating in FETCH and the i_opcode dependence of o_illegal in DECODE. Any output not listed for a state is 0.
- FETCH:
  - Outputs: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite = pcwrite = i_mem_ready.
  - Stay in FETCH while i_mem_ready=0; go to DECODE when it is 1.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=00.
  - Next state by opcode: LW/SW to MEMADR, RTYPE to RTYPEEX, BEQ to BEQEX, ADDI to ADDIEX, J to JEX.
  - Any other opcode: o_illegal=1 this cycle and next state is FETCH.
- MEMADR:
  - Outputs: alusrca=1, alusrcb=10, aluop=00.
  - Next state: MEMRD if the opcode is LW, else MEMWR. Opcode is held stable by the IR.
- MEMRD:
  - Outputs: iord=1.
  - Stay until i_mem_ready=1, then go to MEMWB.
- MEMWB:
  - Outputs: regdst=0, memtoreg=1, regwrite=1.
  - Next state: FETCH.
- MEMWR:
  - Outputs: iord=1, memwrite=1, held for every cycle in the state.
  - Stay until i_mem_ready=1, then go to FETCH.
- RTYPEEX:
  - Outputs: alusrca=1, alusrcb=00, aluop=10.
  - Next state: RTYPEWB.
- RTYPEWB:
  - Outputs: regdst=1, memtoreg=0, regwrite=1.
  - Next state: FETCH.
- BEQEX:
  - Outputs: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - Next state: FETCH.
- ADDIEX:
  - Outputs: alusrca=1, alusrcb=10, aluop=00.
  - Next state: ADDIWB.
- ADDIWB:
  - Outputs: regdst=0, memtoreg=0, regwrite=1.
  - Next state: FETCH.
- JEX:
  - Outputs: pcsrc=10, pcwrite=1.
  - Next state: FETCH.
- o_aluop is never 11.
- Cycle counts with zero memory wait:
  - LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Each wait cycle on i_mem_ready adds one cycle in FETCH, MEMRD or MEMWR.
- No write enable is asserted in two consecutive states of one instruction, except memwrite during a MEMWR stall.

Test Plan:
- Reset check: assert i_rst for 2 cycles from state RTYPEEX (6) -> o_state=0 after the first edge; all enables 0 during reset; FETCH with i_mem_ready=1 gives irwrite=pcwrite=1, alusrcb=01.
- LW, i_mem_ready=1 throughout -> states 0,1,2,3,4,0; aluop=00 in 2; iord=1 in 3; regwrite=1 with memtoreg=1 only in 4.
- SW with i_mem_ready=0 for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then state 0.
- R-type (opcode 000000) -> states 0,1,6,7,0; aluop=10 only in 6; regdst=1 and regwrite=1 in 7. BEQ -> 0,1,8,0 with aluop=01, branch=1, pcsrc=01 in 8.
- FETCH stall: i_mem_ready=0 for 2 cycles -> irwrite=pcwrite=0 and state stays 0, then one cycle with both =1, then DECODE.
- Opcode 111111 -> o_illegal=1 for exactly one cycle in DECODE, next state 0, no regwrite or memwrite asserted. J -> states 0,1,11,0 with pcsrc=10, pcwrite=1.

Source files
------------

// File: rtl/mips_main_fsm.sv
// mips_main_fsm -- main control FSM for the multicycle MIPS datapath.
//
// Sequences each instruction through fetch, decode, execute, memory and
// writeback, and drives every datapath mux select and write enable. Fetch
// and data accesses stall on i_mem_ready so slow memory can hold the FSM.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset (forces FETCH, gates enables)
//   i_opcode     instr[31:26] from the instruction register
//   i_mem_ready  memory finished the current access this cycle
//   o_aluop      ALU operation class: 00 add, 01 sub, 10 use funct
//   o_alusrca    0 = PC, 1 = register A
//   o_alusrcb    00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   o_pcsrc      00 = ALU result, 01 = ALUOut, 10 = jump target
//   o_pcwrite    unconditional PC write
//   o_branch     PC write qualified by the zero flag
//   o_iord       0 = PC address, 1 = ALUOut address
//   o_memwrite   memory write strobe
//   o_irwrite    instruction register load
//   o_regdst     0 = rt, 1 = rd
//   o_memtoreg   0 = ALUOut, 1 = memory data
//   o_regwrite   register file write
//   o_illegal    one-cycle pulse in DECODE on an unsupported opcode
//   o_state      current state encoding (debug)
module mips_main_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output logic [1:0] o_aluop,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_pcsrc,
  output logic       o_pcwrite,
  output logic       o_branch,
  output logic       o_iord,
  output logic       o_memwrite,
  output logic       o_irwrite,
  output logic       o_regdst,
  output logic       o_memtoreg,
  output logic       o_regwrite,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  state_e state_q, state_d;
  state_e dec_state;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (i_mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (i_opcode == OP_LW || i_opcode == OP_SW) state_d = S_MEMADR;
        else if (i_opcode == OP_RTYPE)             state_d = S_RTYPEEX;
        else if (i_opcode == OP_BEQ)               state_d = S_BEQEX;
        else if (i_opcode == OP_ADDI)              state_d = S_ADDIEX;
        else if (i_opcode == OP_J)                 state_d = S_JEX;
        else                                       state_d = S_FETCH;
      end
      S_MEMADR:  state_d = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (i_mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (i_mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      // Unused encodings 12-15 recover to FETCH.
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // While reset is held the select outputs show the FETCH decode even if the
  // register has not yet been cleared, so the datapath sees a known setup.
  assign dec_state = i_rst ? S_FETCH : state_q;

  logic [1:0] aluop_c, alusrcb_c, pcsrc_c;
  logic       alusrca_c, iord_c, regdst_c, memtoreg_c;
  logic       pcwrite_c, branch_c, memwrite_c, irwrite_c, regwrite_c, illegal_c;
  logic       opcode_known;

  assign opcode_known = (i_opcode == OP_LW)   || (i_opcode == OP_SW)  ||
                        (i_opcode == OP_RTYPE)|| (i_opcode == OP_BEQ) ||
                        (i_opcode == OP_ADDI) || (i_opcode == OP_J);

  // Output decode of the state; anything not set for a state stays 0.
  always_comb begin
    aluop_c    = 2'b00;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    pcsrc_c    = 2'b00;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    iord_c     = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    regwrite_c = 1'b0;
    illegal_c  = 1'b0;
    case (dec_state)
      S_FETCH: begin
        alusrcb_c = 2'b01;
        // PC+4 and the IR load only commit once the fetch completes.
        irwrite_c = i_mem_ready;
        pcwrite_c = i_mem_ready;
      end
      S_DECODE: begin
        alusrcb_c = 2'b11;
        illegal_c = ~opcode_known;
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
      end
      S_MEMRD:  iord_c = 1'b1;
      S_MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
      end
      S_MEMWR: begin
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca_c = 1'b1;
        aluop_c   = 2'b10;
      end
      S_RTYPEWB: begin
        regdst_c   = 1'b1;
        regwrite_c = 1'b1;
      end
      S_BEQEX: begin
        alusrca_c = 1'b1;
        aluop_c   = 2'b01;
        pcsrc_c   = 2'b01;
        branch_c  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
      end
      S_ADDIWB: regwrite_c = 1'b1;
      S_JEX: begin
        pcsrc_c   = 2'b10;
        pcwrite_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_aluop    = aluop_c;
  assign o_alusrca  = alusrca_c;
  assign o_alusrcb  = alusrcb_c;
  assign o_pcsrc    = pcsrc_c;
  assign o_iord     = iord_c;
  assign o_regdst   = regdst_c;
  assign o_memtoreg = memtoreg_c;
  assign o_pcwrite  = pcwrite_c  & ~i_rst;
  assign o_branch   = branch_c   & ~i_rst;
  assign o_memwrite = memwrite_c & ~i_rst;
  assign o_irwrite  = irwrite_c  & ~i_rst;
  assign o_regwrite = regwrite_c & ~i_rst;
  assign o_illegal  = illegal_c  & ~i_rst;
  assign o_state    = state_q;

endmodule

// File: tb/tb_mips_main_fsm.sv
// Directed testbench for mips_main_fsm. Each check compares {o_state, outputs}
// against a hand-computed 20-bit constant.
module tb_mips_main_fsm;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [5:0] i_opcode;
  logic       i_mem_ready;
  logic [1:0] o_aluop, o_alusrcb, o_pcsrc;
  logic       o_alusrca, o_pcwrite, o_branch, o_iord, o_memwrite, o_irwrite;
  logic       o_regdst, o_memtoreg, o_regwrite, o_illegal;
  logic [3:0] o_state;

  int passed = 0;
  int total  = 0;

  always #5 i_clk = ~i_clk;

  mips_main_fsm dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_mem_ready(i_mem_ready),
    .o_aluop(o_aluop), .o_alusrca(o_alusrca), .o_alusrcb(o_alusrcb),
    .o_pcsrc(o_pcsrc), .o_pcwrite(o_pcwrite), .o_branch(o_branch),
    .o_iord(o_iord), .o_memwrite(o_memwrite), .o_irwrite(o_irwrite),
    .o_regdst(o_regdst), .o_memtoreg(o_memtoreg), .o_regwrite(o_regwrite),
    .o_illegal(o_illegal), .o_state(o_state)
  );

  // Observed bundle: state, aluop, alusrca, alusrcb, pcsrc, pcwrite, branch,
  // iord, memwrite, irwrite, regdst, memtoreg, regwrite, illegal.
  logic [19:0] obs;
  assign obs = {o_state, o_aluop, o_alusrca, o_alusrcb, o_pcsrc, o_pcwrite,
                o_branch, o_iord, o_memwrite, o_irwrite, o_regdst, o_memtoreg,
                o_regwrite, o_illegal};

  // Hand-derived output patterns (16 bits, same order as obs without state).
  localparam logic [15:0] P_F1   = 16'b00_0_01_00_1_0_0_0_1_0_0_0_0; // fetch, ready
  localparam logic [15:0] P_F0   = 16'b00_0_01_00_0_0_0_0_0_0_0_0_0; // fetch, stalled / reset
  localparam logic [15:0] P_DEC  = 16'b00_0_11_00_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] P_DECI = 16'b00_0_11_00_0_0_0_0_0_0_0_0_1;
  localparam logic [15:0] P_ADR  = 16'b00_1_10_00_0_0_0_0_0_0_0_0_0; // memadr / addiex
  localparam logic [15:0] P_MRD  = 16'b00_0_00_00_0_0_1_0_0_0_0_0_0;
  localparam logic [15:0] P_MWB  = 16'b00_0_00_00_0_0_0_0_0_0_1_1_0;
  localparam logic [15:0] P_MWR  = 16'b00_0_00_00_0_0_1_1_0_0_0_0_0;
  localparam logic [15:0] P_REX  = 16'b10_1_00_00_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] P_RWB  = 16'b00_0_00_00_0_0_0_0_0_1_0_1_0;
  localparam logic [15:0] P_BEQ  = 16'b01_1_00_01_0_1_0_0_0_0_0_0_0;
  localparam logic [15:0] P_AWB  = 16'b00_0_00_00_0_0_0_0_0_0_0_1_0;
  localparam logic [15:0] P_JEX  = 16'b00_0_00_10_1_0_0_0_0_0_0_0_0;

  task automatic test_reset();
    logic [19:0] exp_t [8] = '{{4'd0, P_F0}, {4'd0, P_F0}, {4'd0, P_F1}, {4'd1, P_DEC},
                               {4'd6, P_F0}, {4'd0, P_F0}, {4'd0, P_F0}, {4'd0, P_F0}};
    bit rst_t [8] = '{1, 1, 0, 0, 1, 1, 1, 0};
    bit rdy_t [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    i_opcode = 6'b000000;
    i_rst = 1'b1;
    i_mem_ready = 1'b1;
    @(posedge i_clk); #1;
    // Step 4: reset raised while the FSM sits in RTYPEEX.
    for (int i = 0; i < 8; i++) begin
      i_rst = rst_t[i];
      i_mem_ready = rdy_t[i];
      #1;
      total++;
      if (obs !== exp_t[i])
        $display("FAIL reset step %0d: got %h expected %h", i, obs, exp_t[i]);
      else passed++;
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_lw();
    logic [19:0] exp_t [6] = '{{4'd0, P_F1}, {4'd1, P_DEC}, {4'd2, P_ADR},
                               {4'd3, P_MRD}, {4'd4, P_MWB}, {4'd0, P_F0}};
    bit rdy_t [6] = '{1, 1, 1, 1, 1, 0};
    i_opcode = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      i_mem_ready = rdy_t[i];
      #1;
      total++;
      if (obs !== exp_t[i])
        $display("FAIL lw step %0d: got %h expected %h", i, obs, exp_t[i]);
      else passed++;
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_sw_stall();
    logic [19:0] exp_t [8] = '{{4'd0, P_F1}, {4'd1, P_DEC}, {4'd2, P_ADR},
                               {4'd5, P_MWR}, {4'd5, P_MWR}, {4'd5, P_MWR},
                               {4'd5, P_MWR}, {4'd0, P_F0}};
    bit rdy_t [8] = '{1, 1, 1, 0, 0, 0, 1, 0};
    i_opcode = 6'b101011;
    for (int i = 0; i < 8; i++) begin
      i_mem_ready = rdy_t[i];
      #1;
      total++;
      if (obs !== exp_t[i])
        $display("FAIL sw_stall step %0d: got %h expected %h", i, obs, exp_t[i]);
      else passed++;
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_rtype();
    logic [19:0] exp_t [5] = '{{4'd0, P_F1}, {4'd1, P_DEC}, {4'd6, P_REX},
                               {4'd7, P_RWB}, {4'd0, P_F0}};
    bit rdy_t [5] = '{1, 1, 1, 1, 0};
    i_opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      i_mem_ready = rdy_t[i];
      #1;
      total++;
      if (obs !== exp_t[i])
        $display("FAIL rtype step %0d: got %h expected %h", i, obs, exp_t[i]);
      else passed++;
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_beq();
    logic [19:0] exp_t [4] = '{{4'd0, P_F1}, {4'd1, P_DEC}, {4'd8, P_BEQ}, {4'd0, P_F0}};
    bit rdy_t [4] = '{1, 1, 1, 0};
    i_opcode = 6'b000100;
    for (int i = 0; i < 4; i++) begin
      i_mem_ready = rdy_t[i];
      #1;
      total++;
      if (obs !== exp_t[i])
        $display("FAIL beq step %0d: got %h expected %h", i, obs, exp_t[i]);
      else passed++;
      @(posedge i_clk); #1;
    end
  endtask

  // Fetch stall of two cycles followed by a complete ADDI.
  task automatic test_fetch_stall_addi();
    logic [19:0] exp_t [7] = '{{4'd0, P_F0}, {4'd0, P_F0}, {4'd0, P_F1}, {4'd1, P_DEC},
                               {4'd9, P_ADR}, {4'd10, P_AWB}, {4'd0, P_F0}};
    bit rdy_t [7] = '{0, 0, 1, 0, 0, 0, 0};
    i_opcode = 6'b001000;
    for (int i = 0; i < 7; i++) begin
      i_mem_ready = rdy_t[i];
      #1;
      total++;
      if (obs !== exp_t[i])
        $display("FAIL fetch_stall_addi step %0d: got %h expected %h", i, obs, exp_t[i]);
      else passed++;
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [19:0] exp_t [3] = '{{4'd0, P_F1}, {4'd1, P_DECI}, {4'd0, P_F0}};
    bit rdy_t [3] = '{1, 1, 0};
    i_opcode = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      i_mem_ready = rdy_t[i];
      #1;
      total++;
      if (obs !== exp_t[i])
        $display("FAIL illegal step %0d: got %h expected %h", i, obs, exp_t[i]);
      else passed++;
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_jump();
    logic [19:0] exp_t [4] = '{{4'd0, P_F1}, {4'd1, P_DEC}, {4'd11, P_JEX}, {4'd0, P_F0}};
    bit rdy_t [4] = '{1, 1, 1, 0};
    i_opcode = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      i_mem_ready = rdy_t[i];
      #1;
      total++;
      if (obs !== exp_t[i])
        $display("FAIL jump step %0d: got %h expected %h", i, obs, exp_t[i]);
      else passed++;
      @(posedge i_clk); #1;
    end
  endtask

  // Back-to-back instructions with no idle cycle: ADDI directly followed by J.
  task automatic test_back_to_back();
    logic [19:0] exp_t [8] = '{{4'd0, P_F1}, {4'd1, P_DEC}, {4'd9, P_ADR}, {4'd10, P_AWB},
                               {4'd0, P_F1}, {4'd1, P_DEC}, {4'd11, P_JEX}, {4'd0, P_F0}};
    logic [5:0] op_t [8] = '{6'b001000, 6'b001000, 6'b001000, 6'b001000,
                             6'b000010, 6'b000010, 6'b000010, 6'b000010};
    bit rdy_t [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      i_opcode = op_t[i];
      i_mem_ready = rdy_t[i];
      #1;
      total++;
      if (obs !== exp_t[i])
        $display("FAIL back_to_back step %0d: got %h expected %h", i, obs, exp_t[i]);
      else passed++;
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_opcode = 6'b000000;
    i_mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype();
    test_beq();
    test_fetch_stall_addi();
    test_illegal();
    test_jump();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
